tdm_demux_1_4: RTL and testbench
================================

TDM_DEMUX_1_4 -- requirements
Module: tdm_demux_1_4

Interface
Parameters: none.
REQ-001 clk  input  1  system clock; all state updates on the rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 en  input  1  slot strobe; exactly one TDM slot is consumed per rising clk edge with en=1.
REQ-004 frame  input  1  start-of-frame marker, qualified by en; marks the current d as slot 0.
REQ-005 d  input  1  serial TDM data; slots 0..3 arrive in order, one per strobe.
REQ-006 slot  output  2  index of the slot the next strobe captures; it mirrors the select of the transmitting 4:1 mux.
REQ-007 q  output  4  q[k] holds slot k of the last complete frame.
REQ-008 q_valid  output  1  one-cycle pulse when q is updated.
REQ-009 sync  output  1  1 while the frame alignment is locked.
REQ-010 frame_err  output  1  sticky flag for a misaligned frame marker.

Function
REQ-011 The block SHALL implement a two-state FSM: HUNT (not aligned) and LOCK (aligned).
REQ-012 The block SHALL hold a 3-bit shadow register for slots 0..2 of the frame in progress.
REQ-013 With en=0, the block SHALL hold state, slot, shadow, q and frame_err, and drive q_valid=0.
REQ-014 In HUNT with en=1 and frame=0, the block SHALL discard d and hold slot=0.
REQ-015 In HUNT with en=1 and frame=1, the block SHALL write shadow[0]=d, set slot=1 and enter LOCK.
REQ-016 In LOCK with en=1 and slot in 0..2, the block SHALL write shadow[slot]=d and set slot=slot+1.
REQ-017 In LOCK with en=1 and slot=3, the block SHALL load q={d, shadow[2:0]}, wrap slot to 0, and assert q_valid on that same edge for exactly one cycle.
REQ-018 Latency: q SHALL change on the edge that samples slot 3; there SHALL be zero added cycles between that edge and q/q_valid.
REQ-019 In LOCK, frame=1 at slot=0 SHALL be accepted as normal alignment.
REQ-020 In LOCK, frame=0 at slot=0 SHALL also be accepted; markers are optional once locked (free-running).
REQ-021 In LOCK, frame=1 with en=1 at slot!=0 SHALL handle the misalignment as follows:
 - set frame_err=1;
 - discard the partial frame with no q_valid and q unchanged;
 - write shadow[0]=d, set slot=1 and remain in LOCK (resync).
REQ-022 The resync of REQ-021 at slot=3 SHALL take precedence over the frame completion of REQ-017.
REQ-023 frame_err SHALL stay at 1 until rst.
REQ-024 sync SHALL equal 1 exactly when the state is LOCK.
REQ-025 q SHALL never show a mix of two frames; all four bits update atomically.
REQ-026 The block SHALL have no combinational path from any input to any output; all outputs are registered.

Reset
REQ-027 While rst=1, the block SHALL force state=HUNT, slot=0, shadow=0, q=0, q_valid=0, sync=0 and frame_err=0, independent of clk.
REQ-028 When rst asserts mid-frame, the block SHALL discard the partial frame and SHALL NOT pulse q_valid.
REQ-029 After rst deasserts, the block SHALL wait in HUNT for en=1 with frame=1.

Verification
REQ-030 Basic frame: after reset, en=1 every cycle, frame=1 on the first cycle, d=1,0,1,1 -> on the 4th edge q=4'b1101, q_valid high for 1 cycle, sync=1.
REQ-031 Hunt discard: d=1,1 with frame=0, then frame=1 with d=0,1,0,0 -> q=4'b0010; no q_valid before the 4th post-frame strobe.
REQ-032 Strobe gaps: the same frame as REQ-030 with en=0 for 3 cycles between each slot -> q=4'b1101, slot holds during the gaps, exactly one q_valid.
REQ-033 Misaligned marker: locked, frame=1 at slot=2 -> frame_err=1, q unchanged, no q_valid, slot=1; the next 3 strobes d=1,1,1 after marker d=0 -> q=4'b1110.
REQ-034 Back-to-back frames: frames 0xA then 0x5 continuously with no markers after the first -> q=4'hA then 4'h5, two q_valid pulses 4 cycles apart.
REQ-035 Async reset: rst asserted mid-frame between clk edges -> all outputs 0 immediately; after release, d without a marker is ignored.

Source files
------------

// File: rtl/tdm_demux_1_4.sv
// tdm_demux_1_4: 1:4 serial TDM demultiplexer with frame alignment
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         slot strobe, one slot consumed per enabled edge
//   frame      start-of-frame marker (qualified by en), marks d as slot 0
//   d          serial TDM data
//   slot       index of the slot the next strobe captures
//   q          slots 0..3 of the last complete frame
//   q_valid    one-cycle pulse when q updates
//   sync       high while frame alignment is locked
//   frame_err  sticky misaligned-marker flag
module tdm_demux_1_4 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       frame,
   input  logic       d,
   output logic [1:0] slot,
   output logic [3:0] q,
   output logic       q_valid,
   output logic       sync,
   output logic       frame_err
);
   localparam logic [0:0] HUNT = 1'b0;
   localparam logic [0:0] LOCK = 1'b1;
   logic [0:0] state_q, state_d;
   logic [1:0] slot_q, slot_d;
   logic [2:0] sh_q, sh_d;
   logic [3:0] q_q, q_d;
   logic       qv_q, qv_d;
   logic       err_q, err_d;
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      sh_d    = sh_q;
      q_d     = q_q;
      qv_d    = 1'b0;
      err_d   = err_q;
      if (en) begin
         if (state_q == HUNT) begin
            if (frame) begin
               sh_d[0] = d;
               slot_d  = 2'd1;
               state_d = LOCK;
            end
         end else if (frame && slot_q != 2'd0) begin
            // a marker mid-frame restarts the frame; resync beats completion at slot 3
            err_d   = 1'b1;
            sh_d[0] = d;
            slot_d  = 2'd1;
         end else if (slot_q == 2'd3) begin
            q_d    = {d, sh_q};
            slot_d = 2'd0;
            qv_d   = 1'b1;
         end else begin
            sh_d[slot_q] = d;
            slot_d       = slot_q + 2'd1;
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= HUNT;
         slot_q  <= 2'd0;
         sh_q    <= 3'd0;
         q_q     <= 4'd0;
         qv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         sh_q    <= sh_d;
         q_q     <= q_d;
         qv_q    <= qv_d;
         err_q   <= err_d;
      end
   end
   assign slot      = slot_q;
   assign q         = q_q;
   assign q_valid   = qv_q;
   assign sync      = (state_q == LOCK);
   assign frame_err = err_q;
endmodule

// File: tb/tb_tdm_demux_1_4.sv
// tb_tdm_demux_1_4: scoreboard bench for tdm_demux_1_4
module tb_tdm_demux_1_4;
   logic       clk = 1'b0;
   logic       rst, en, frame, d;
   logic [1:0] slot;
   logic [3:0] q;
   logic       q_valid, sync, frame_err;
   int         errs = 0;
   int         checks = 0;
   logic [3:0] expq[$];
   bit         mbits[$];
   bit         mlock, merr, mv;
   logic [3:0] mq;
   tdm_demux_1_4 dut (
      .clk(clk), .rst(rst), .en(en), .frame(frame), .d(d),
      .slot(slot), .q(q), .q_valid(q_valid), .sync(sync), .frame_err(frame_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s actual=%0h required=%0h", n, a, e);
      end
   endtask
   task automatic model_reset();
      mlock = 0;
      merr  = 0;
      mv    = 0;
      mq    = 4'd0;
      mbits.delete();
      expq.delete();
   endtask
   task automatic step(input bit e, input bit f, input bit dd);
      en = e;
      frame = f;
      d = dd;
      @(posedge clk);
      mv = 0;
      if (e) begin
         if (!mlock) begin
            if (f) begin
               mbits.delete();
               mbits.push_back(dd);
               mlock = 1;
            end
         end else if (f && mbits.size() != 0) begin
            merr = 1;
            mbits.delete();
            mbits.push_back(dd);
         end else begin
            mbits.push_back(dd);
            if (mbits.size() == 4) begin
               mq = {mbits[3], mbits[2], mbits[1], mbits[0]};
               expq.push_back(mq);
               mv = 1;
               mbits.delete();
            end
         end
      end
      #1;
   endtask
   task automatic send(input logic [3:0] v, input bit mark, input int gap);
      for (int i = 0; i < 4; i++) begin
         step(1, mark && i == 0, v[i]);
         for (int g = 0; g < gap; g++) step(0, 0, 0);
      end
   endtask
   task automatic mid_reset();
      @(posedge clk);
      #2 rst = 1;
      model_reset();
      #1;
      chk("rst_q", q, 0);
      chk("rst_slot", slot, 0);
      chk("rst_qv", q_valid, 0);
      chk("rst_sync", sync, 0);
      chk("rst_err", frame_err, 0);
      @(posedge clk);
      #1 rst = 0;
   endtask
   always @(negedge clk) begin
      if (q_valid) begin
         if (expq.size() == 0) chk("spurious_q_valid", 1, 0);
         else chk("q_valid_data", q, expq.pop_front());
      end
      chk("q_valid", q_valid, mv);
      chk("q", q, mq);
      chk("slot", slot, mlock ? mbits.size() : 0);
      chk("sync", sync, mlock);
      chk("frame_err", frame_err, merr);
   end
   initial begin
      rst = 1;
      en = 0;
      frame = 0;
      d = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 0;
      send(4'b1101, 1, 0);
      chk("basic_q", q, 4'b1101);
      chk("basic_qv", q_valid, 1);
      chk("basic_sync", sync, 1);
      mid_reset();
      step(1, 0, 1);
      step(1, 0, 1);
      chk("hunt_slot", slot, 0);
      send(4'b0010, 1, 0);
      chk("hunt_q", q, 4'b0010);
      mid_reset();
      send(4'b1101, 1, 3);
      chk("gap_q", q, 4'b1101);
      step(1, 1, 1);
      step(1, 0, 0);
      step(1, 1, 0);
      chk("mis_err", frame_err, 1);
      chk("mis_slot", slot, 1);
      chk("mis_q", q, 4'b1101);
      step(1, 0, 1);
      step(1, 0, 1);
      step(1, 0, 1);
      chk("mis_resync_q", q, 4'b1110);
      step(1, 0, 1);
      step(1, 0, 1);
      step(1, 0, 1);
      step(1, 1, 0);
      chk("slot3_resync_slot", slot, 1);
      mid_reset();
      send(4'hA, 1, 0);
      chk("b2b_a", q, 4'hA);
      send(4'h5, 0, 0);
      chk("b2b_5", q, 4'h5);
      step(1, 1, 1);
      step(1, 0, 0);
      mid_reset();
      for (int i = 0; i < 4; i++) step(1, 0, 1);
      chk("post_rst_sync", sync, 0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) mid_reset();
         step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)));
      end
      step(0, 0, 0);
      chk("scoreboard_drained", expq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
